// File: rtl/pmeter_pkg.sv
// Shared types and constants for the prescaler period meter.
// Results carry a maximum-width period; users keep the low W bits.
package pmeter_pkg;

  localparam int NCH   = 4;
  localparam int W_DEF = 16;
  localparam int W_MAX = 32;

  typedef logic [1:0] ch_t;

  typedef struct packed {
    logic [W_MAX-1:0] period;
    logic             ovf;
    logic             drop;
  } result_t;

  // Round-robin pick: first requester after last; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(
    input ch_t            last,
    input logic [NCH-1:0] req
  );
    ch_t idx;
    for (int k = 1; k <= NCH; k++) begin
      idx = last + ch_t'(k);
      if (req[idx]) return {1'b1, idx};
    end
    return 3'b000;
  endfunction

endpackage

// File: rtl/pmeter_channel.sv
// One measurement channel: synchronizer, edge detect, period counter,
// capture register and pending/drop bookkeeping.
module pmeter_channel
  import pmeter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    pin,
  input  logic    grant,
  output result_t res,
  output logic    pending
);

  localparam logic [W-1:0] MAX = '1;

  logic [1:0]   sync;
  logic         sync_d;
  logic         rise;
  logic         armed;
  logic         cap;
  logic [W-1:0] cnt;
  logic [W-1:0] per;
  logic         ovf;
  logic         drop;

  assign rise = sync[1] & ~sync_d;
  assign cap  = rise & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      sync_d  <= 1'b0;
      cnt     <= '0;
      armed   <= 1'b0;
      per     <= '0;
      ovf     <= 1'b0;
      pending <= 1'b0;
      drop    <= 1'b0;
    end else begin
      sync   <= {sync[0], pin};
      sync_d <= sync[1];

      if (rise)
        cnt <= '0;
      else if (cnt != MAX)
        cnt <= cnt + 1'b1;

      if (rise)
        armed <= 1'b1;

      // A grant in the capture cycle takes the old value, so no drop.
      if (cap) begin
        per     <= (cnt == MAX) ? MAX : cnt + 1'b1;
        ovf     <= (cnt == MAX);
        pending <= 1'b1;
        drop    <= pending & ~grant;
      end else if (grant) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end
    end
  end

  assign res = '{period: W_MAX'(per), ovf: ovf, drop: drop};

endmodule

// File: rtl/prescaler_meter.sv
// Four-channel period meter: per-channel capture plus a round-robin
// arbiter feeding a single valid/ready output register.
module prescaler_meter
  import pmeter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK_IN,
  input  logic         RST,
  input  logic         PIN_1,
  input  logic         PIN_2,
  input  logic         PIN_3,
  input  logic         PIN_4,
  input  logic         READY,
  output logic [W-1:0] PERIOD,
  output ch_t          CH,
  output logic         OVF,
  output logic         DROP,
  output logic         VALID
);

  logic [NCH-1:0] pins;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grant;
  result_t        res [NCH];
  ch_t            last;
  logic [2:0]     pick;
  logic           hit;
  ch_t            sel;
  logic           load;

  assign pins = {PIN_4, PIN_3, PIN_2, PIN_1};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pmeter_channel #(
      .W(W)
    ) u_ch (
      .clk    (CLK_IN),
      .rst    (RST),
      .pin    (pins[i]),
      .grant  (grant[i]),
      .res    (res[i]),
      .pending(pend[i])
    );
  end

  if (W < W_MAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{res[0].period[W_MAX-1:W],
                         res[1].period[W_MAX-1:W],
                         res[2].period[W_MAX-1:W],
                         res[3].period[W_MAX-1:W]};
  end

  always_comb begin
    pick  = rr_pick(last, pend);
    hit   = pick[2];
    sel   = pick[1:0];
    load  = ~VALID | READY;
    grant = '0;
    if (load && hit)
      grant[sel] = 1'b1;
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      VALID  <= 1'b0;
      PERIOD <= '0;
      CH     <= '0;
      OVF    <= 1'b0;
      DROP   <= 1'b0;
      last   <= 2'd3;
    end else if (load) begin
      if (hit) begin
        VALID  <= 1'b1;
        PERIOD <= res[sel].period[W-1:0];
        CH     <= sel;
        OVF    <= res[sel].ovf;
        DROP   <= res[sel].drop;
        last   <= sel;
      end else begin
        VALID  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prescaler_meter.sv
// Directed bench for prescaler_meter: table-driven steady-state check
// plus hand-written sequences for stall, reset, overflow and grant races.
module tb_prescaler_meter;

  typedef struct {
    int ch;
    int period;
    int ovf;
    int drop;
  } rec_t;

  typedef struct {
    int ch;
    int period;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pins;
  logic        ready;
  logic [15:0] period;
  logic [1:0]  ch;
  logic        ovf;
  logic        drop;
  logic        valid;

  logic        pin4a;
  logic        zero4;
  logic        ready4;
  logic [3:0]  period4;
  logic [1:0]  ch4;
  logic        ovf4;
  logic        drop4;
  logic        valid4;

  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;
  int   cnt      = 0;
  rec_t q[$];
  rec_t q4[$];
  rec_t mr;
  rec_t mr4;
  vec_t steady[15];

  always #5 clk = ~clk;

  prescaler_meter #(.W(16)) dut (
    .CLK_IN(clk), .RST(rst),
    .PIN_1(pins[0]), .PIN_2(pins[1]),
    .PIN_3(pins[2]), .PIN_4(pins[3]),
    .READY(ready), .PERIOD(period), .CH(ch),
    .OVF(ovf), .DROP(drop), .VALID(valid)
  );

  prescaler_meter #(.W(4)) dut4 (
    .CLK_IN(clk), .RST(rst),
    .PIN_1(pin4a), .PIN_2(zero4),
    .PIN_3(zero4), .PIN_4(zero4),
    .READY(ready4), .PERIOD(period4), .CH(ch4),
    .OVF(ovf4), .DROP(drop4), .VALID(valid4)
  );

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      mr.ch = int'(ch);
      mr.period = int'(period);
      mr.ovf = int'(ovf);
      mr.drop = int'(drop);
      q.push_back(mr);
    end
    if (valid4 === 1'b1 && ready4 === 1'b1) begin
      mr4.ch = int'(ch4);
      mr4.period = int'(period4);
      mr4.ovf = int'(ovf4);
      mr4.drop = int'(drop4);
      q4.push_back(mr4);
    end
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int i, input int ech,
                       input int eper, input int eovf, input int edrop);
    if (i >= q.size()) begin
      chk($sformatf("%s[%0d]_missing", name, i), q.size(), i + 1);
    end else begin
      chk($sformatf("%s[%0d]_ch", name, i), q[i].ch, ech);
      chk($sformatf("%s[%0d]_period", name, i), q[i].period, eper);
      chk($sformatf("%s[%0d]_ovf", name, i), q[i].ovf, eovf);
      chk($sformatf("%s[%0d]_drop", name, i), q[i].drop, edrop);
    end
  endtask

  task automatic chk_q4(input int i, input int eper, input int eovf);
    if (i >= q4.size()) begin
      chk($sformatf("w4[%0d]_missing", i), q4.size(), i + 1);
    end else begin
      chk($sformatf("w4[%0d]_ch", i), q4[i].ch, 0);
      chk($sformatf("w4[%0d]_period", i), q4[i].period, eper);
      chk($sformatf("w4[%0d]_ovf", i), q4[i].ovf, eovf);
      chk($sformatf("w4[%0d]_drop", i), q4[i].drop, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mode == 1) begin
      cnt++;
      pins = cnt[3:0];
    end else if (mode == 2) begin
      cnt++;
      pins = {4{cnt[0]}};
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    mode = 0;
    cnt  = 0;
    pins = '0;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
    q4.delete();
  endtask

  task automatic wave4(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      pin4a = 1'b1;
      repeat (per / 2) tick();
      pin4a = 1'b0;
      repeat (per / 2) tick();
    end
  endtask

  initial begin
    int   vcnt;
    logic [15:0] hp;
    logic [1:0]  hc;
    logic        hd;
    logic        stable;

    // Steady pattern for divide-by-2..16 pins, one 16-cycle block
    steady[0]  = '{0, 2};
    steady[1]  = '{1, 4};
    steady[2]  = '{0, 2};
    steady[3]  = '{2, 8};
    steady[4]  = '{0, 2};
    steady[5]  = '{1, 4};
    steady[6]  = '{0, 2};
    steady[7]  = '{3, 16};
    steady[8]  = '{0, 2};
    steady[9]  = '{1, 4};
    steady[10] = '{0, 2};
    steady[11] = '{2, 8};
    steady[12] = '{0, 2};
    steady[13] = '{1, 4};
    steady[14] = '{0, 2};

    rst    = 1'b1;
    pins   = '0;
    ready  = 1'b1;
    pin4a  = 1'b0;
    zero4  = 1'b0;
    ready4 = 1'b1;
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_period", period, 0);
    chk("rst_ch", ch, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    chk("rst_valid4", valid4, 0);

    // Single arming edge, then a second edge 6 cycles later on PIN_3
    do_reset();
    ready = 1'b1;
    tick();
    tick();
    pins[2] = 1'b1;
    vcnt = 0;
    repeat (3) begin tick(); vcnt += int'(valid); end
    pins[2] = 1'b0;
    repeat (3) begin tick(); vcnt += int'(valid); end
    chk("arm_no_valid", vcnt, 0);
    pins[2] = 1'b1;
    vcnt = 0;
    repeat (3) begin tick(); vcnt += int'(valid); end
    chk("lat_before4", vcnt, 0);
    tick();
    chk("lat_valid", valid, 1);
    chk("lat_ch", ch, 2);
    chk("lat_period", period, 6);
    chk("lat_ovf", ovf, 0);
    chk("lat_drop", drop, 0);
    tick();
    chk("lat_done", valid, 0);

    // Prescaler-driven pins, periods 2/4/8/16, READY held high
    do_reset();
    ready = 1'b1;
    mode  = 1;
    repeat (60) tick();
    mode = 0;
    repeat (8) tick();
    chk("steady_count", q.size(), 53);
    chk_q("steady_first", 0, 0, 2, 0, 0);
    chk_q("steady_first", 2, 1, 4, 0, 0);
    for (int j = 0; j < 30; j++)
      chk_q("steady", 11 + j, steady[j % 15].ch,
            steady[j % 15].period, 0, 0);

    // W=4 saturation then a measurable period
    do_reset();
    pin4a = 1'b0;
    wave4(20, 3);
    wave4(10, 2);
    pin4a = 1'b1;
    repeat (30) tick();
    chk("w4_count", q4.size(), 5);
    chk_q4(0, 15, 1);
    chk_q4(1, 15, 1);
    chk_q4(2, 15, 1);
    chk_q4(3, 10, 0);
    chk_q4(4, 10, 0);

    // All channels period 2 while READY is low for 20 cycles
    do_reset();
    ready = 1'b0;
    mode  = 2;
    repeat (10) tick();
    hp = period;
    hc = ch;
    hd = drop;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (valid !== 1'b1 || period !== hp || ch !== hc || drop !== hd)
        stable = 1'b0;
    end
    chk("stall_valid", valid, 1);
    chk("stall_stable", stable, 1);
    chk("stall_ch", hc, 0);
    chk("stall_period", hp, 2);
    mode = 0;
    repeat (4) tick();
    q.delete();
    ready = 1'b1;
    repeat (8) tick();
    chk("stall_count", q.size(), 5);
    chk_q("stall", 0, 0, 2, 0, 0);
    chk_q("stall", 1, 1, 2, 0, 1);
    chk_q("stall", 2, 2, 2, 0, 1);
    chk_q("stall", 3, 3, 2, 0, 1);
    chk_q("stall", 4, 0, 2, 0, 1);
    q.delete();
    pins = '0;
    repeat (3) tick();
    pins = '1;
    repeat (10) tick();
    chk("after_count", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        chk($sformatf("after[%0d]_ch", i), q[i].ch, (i + 1) % 4);
        chk($sformatf("after[%0d]_drop", i), q[i].drop, 0);
      end
    end

    // Reset while a result is presented and others are pending
    do_reset();
    ready = 1'b0;
    mode  = 2;
    repeat (12) tick();
    chk("pre_rst_valid", valid, 1);
    mode = 0;
    rst  = 1'b1;
    tick();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_period", period, 0);
    pins  = '0;
    rst   = 1'b0;
    ready = 1'b1;
    q.delete();
    tick();
    tick();
    pins = '1;
    vcnt = 0;
    repeat (10) begin tick(); vcnt += int'(valid); end
    chk("rearm_no_valid", vcnt, 0);
    pins = '0;
    repeat (3) tick();
    pins = '1;
    repeat (10) tick();
    chk("rearm_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_q("rearm", i, i, 13, 0, 0);

    // CH1 captures 4 in the same cycle its staged 5 is granted
    do_reset();
    ready = 1'b0;
    pins[0] = 1'b1;
    tick();
    pins[0] = 1'b0;
    repeat (3) tick();
    pins[0] = 1'b1;
    repeat (6) tick();
    chk("race_busy_valid", valid, 1);
    chk("race_busy_ch", ch, 0);
    chk("race_busy_period", period, 4);
    pins[1] = 1'b1;
    tick();
    pins[1] = 1'b0;
    repeat (4) tick();
    pins[1] = 1'b1;
    tick();
    pins[1] = 1'b0;
    repeat (3) tick();
    pins[1] = 1'b1;
    tick();
    tick();
    ready = 1'b1;
    tick();
    chk("race_old_valid", valid, 1);
    chk("race_old_ch", ch, 1);
    chk("race_old_period", period, 5);
    chk("race_old_drop", drop, 0);
    tick();
    chk("race_new_ch", ch, 1);
    chk("race_new_period", period, 4);
    chk("race_new_drop", drop, 0);
    tick();
    chk("race_idle", valid, 0);
    chk("race_count", q.size(), 3);
    chk_q("race", 0, 0, 4, 0, 0);
    chk_q("race", 1, 1, 5, 0, 0);
    chk_q("race", 2, 1, 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
